// File: rtl/addr_sequencer.sv
// Read-address sequencer: load/start in IDLE, strided modulo-DEPTH bursts under valid/ready.
// Optional abort/aborted ports are enabled by defining ADDR_SEQ_ABORT_EN.
module addr_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              start,
  input  logic [ADDR_W-1:0] burst_len,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  input  logic              addr_ready,
`ifdef ADDR_SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              addr_valid,
  output logic [ADDR_W-1:0] read_address,
  output logic              busy,
  output logic              done,
  output logic              wrapped
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_L = AW1'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] remaining;
  logic [STEP_W-1:0] step_r;
  logic              dir_r;

  logic [ADDR_W:0]   addr_x;
  logic [ADDR_W:0]   step_x;
  logic [ADDR_W:0]   inc_sum;
  logic [ADDR_W-1:0] next_addr;
  logic              next_wrap;
  logic              beat;
  logic              abort_req;

  // Wrap arithmetic is one bit wider than the address so DEPTH == 2^ADDR_W works.
  always_comb begin
    addr_x    = {1'b0, read_address};
    step_x    = AW1'(step_r);
    inc_sum   = addr_x + step_x;
    next_addr = ADDR_W'(inc_sum);
    next_wrap = 1'b0;
    if (!dir_r) begin
      if (inc_sum >= DEPTH_L) begin
        next_addr = ADDR_W'(inc_sum - DEPTH_L);
        next_wrap = 1'b1;
      end
    end else if (addr_x < step_x) begin
      next_addr = ADDR_W'(addr_x + DEPTH_L - step_x);
      next_wrap = 1'b1;
    end else begin
      next_addr = ADDR_W'(addr_x - step_x);
    end
  end

  always_comb begin
    beat      = (state == RUN) && addr_valid && addr_ready;
    abort_req = 1'b0;
`ifdef ADDR_SEQ_ABORT_EN
    abort_req = (state == RUN) && abort;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      read_address <= '0;
      remaining    <= '0;
      step_r       <= '0;
      dir_r        <= 1'b0;
      addr_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wrapped      <= 1'b0;
`ifdef ADDR_SEQ_ABORT_EN
      aborted      <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      wrapped <= 1'b0;
`ifdef ADDR_SEQ_ABORT_EN
      aborted <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (load) read_address <= ADDR_W'({1'b0, load_value} % DEPTH_L);
          if (start) begin
            remaining <= burst_len;
            step_r    <= step;
            dir_r     <= dir;
            busy      <= 1'b1;
            if (burst_len != '0) begin
              state      <= RUN;
              addr_valid <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (beat) begin
            read_address <= next_addr;
            wrapped      <= next_wrap;
            remaining    <= remaining - ADDR_W'(1);
          end
          if ((beat && remaining == ADDR_W'(1)) || abort_req) begin
            state      <= DONE;
            addr_valid <= 1'b0;
            done       <= 1'b1;
`ifdef ADDR_SEQ_ABORT_EN
            aborted    <= abort_req;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_sequencer.sv
// Directed bench for addr_sequencer (ADDR_W=8, DEPTH=256, STEP_W=4) with hand-computed expectations.
module tb_addr_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic [7:0] burst_len;
  logic [3:0] step;
  logic       dir;
  logic       addr_ready;
  logic       addr_valid;
  logic [7:0] read_address;
  logic       busy;
  logic       done;
  logic       wrapped;
`ifdef ADDR_SEQ_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  addr_sequencer #(.ADDR_W(8), .DEPTH(256), .STEP_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .load_value   (load_value),
    .start        (start),
    .burst_len    (burst_len),
    .step         (step),
    .dir          (dir),
    .addr_ready   (addr_ready),
`ifdef ADDR_SEQ_ABORT_EN
    .abort        (abort),
    .aborted      (aborted),
`endif
    .addr_valid   (addr_valid),
    .read_address (read_address),
    .busy         (busy),
    .done         (done),
    .wrapped      (wrapped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packs {addr_valid, busy, done, wrapped, read_address} for compact checks.
  function automatic logic [31:0] outs();
    return {20'd0, addr_valid, busy, done, wrapped, read_address};
  endfunction

  function automatic logic [31:0] exp_outs(input logic v, input logic b, input logic d,
                                           input logic w, input logic [7:0] a);
    return {20'd0, v, b, d, w, a};
  endfunction

  initial begin
    reset = 1'b1; load = 1'b0; load_value = '0; start = 1'b0;
    burst_len = '0; step = '0; dir = 1'b0; addr_ready = 1'b0;
`ifdef ADDR_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    chk("reset", outs(), exp_outs(0, 0, 0, 0, 8'h00));
    reset = 1'b0;
    tick();

    // Test 1: load 10, burst of 4 at step 1 up.
    load = 1'b1; load_value = 8'h10;
    tick();
    load = 1'b0;
    chk("t1_load", outs(), exp_outs(0, 0, 0, 0, 8'h10));
    start = 1'b1; burst_len = 8'd4; step = 4'd1; dir = 1'b0; addr_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_b0", outs(), exp_outs(1, 1, 0, 0, 8'h10));
    tick(); chk("t1_b1", outs(), exp_outs(1, 1, 0, 0, 8'h11));
    tick(); chk("t1_b2", outs(), exp_outs(1, 1, 0, 0, 8'h12));
    tick(); chk("t1_b3", outs(), exp_outs(1, 1, 0, 0, 8'h13));
    tick(); chk("t1_done", outs(), exp_outs(0, 1, 1, 0, 8'h14));
    tick(); chk("t1_idle", outs(), exp_outs(0, 0, 0, 0, 8'h14));

    // Test 2: load+start together, FE step 3 up, wraps to 01.
    load = 1'b1; load_value = 8'hFE;
    start = 1'b1; burst_len = 8'd3; step = 4'd3; dir = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
    chk("t2_b0", outs(), exp_outs(1, 1, 0, 0, 8'hFE));
    tick(); chk("t2_b1_wrap", outs(), exp_outs(1, 1, 0, 1, 8'h01));
    tick(); chk("t2_b2", outs(), exp_outs(1, 1, 0, 0, 8'h04));
    tick(); chk("t2_done", outs(), exp_outs(0, 1, 1, 0, 8'h07));
    tick(); chk("t2_idle", outs(), exp_outs(0, 0, 0, 0, 8'h07));

    // Test 3: from 02, step 4 down, ready toggling 0,1,0,1.
    load = 1'b1; load_value = 8'h02;
    start = 1'b1; burst_len = 8'd2; step = 4'd4; dir = 1'b1; addr_ready = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
    chk("t3_first", outs(), exp_outs(1, 1, 0, 0, 8'h02));
    tick(); chk("t3_stall0", outs(), exp_outs(1, 1, 0, 0, 8'h02));
    addr_ready = 1'b1;
    tick(); chk("t3_beat1_wrap", outs(), exp_outs(1, 1, 0, 1, 8'hFE));
    addr_ready = 1'b0;
    tick(); chk("t3_stall1", outs(), exp_outs(1, 1, 0, 0, 8'hFE));
    addr_ready = 1'b1;
    tick(); chk("t3_done", outs(), exp_outs(0, 1, 1, 0, 8'hFA));
    tick(); chk("t3_idle", outs(), exp_outs(0, 0, 0, 0, 8'hFA));

    // Test 4: zero-length burst.
    start = 1'b1; burst_len = 8'd0; step = 4'd1; dir = 1'b0;
    tick();
    start = 1'b0;
    chk("t4_done", outs(), exp_outs(0, 1, 1, 0, 8'hFA));
    tick(); chk("t4_idle", outs(), exp_outs(0, 0, 0, 0, 8'hFA));

    // Test 5: load/start in RUN ignored, then async reset mid-burst.
    start = 1'b1; burst_len = 8'd5; step = 4'd1; dir = 1'b0;
    tick();
    start = 1'b0;
    chk("t5_b0", outs(), exp_outs(1, 1, 0, 0, 8'hFA));
    load = 1'b1; load_value = 8'h33; start = 1'b1; burst_len = 8'd0; step = 4'd7;
    tick();
    load = 1'b0; start = 1'b0;
    chk("t5_run_load_ignored", outs(), exp_outs(1, 1, 0, 0, 8'hFB));
    tick(); chk("t5_b2_step_kept", outs(), exp_outs(1, 1, 0, 0, 8'hFC));
    #2 reset = 1'b1;
    #1 chk("t5_async_reset", outs(), exp_outs(0, 0, 0, 0, 8'h00));
    tick();
    chk("t5_reset_no_done", outs(), exp_outs(0, 0, 0, 0, 8'h00));
    reset = 1'b0;
    tick();
    start = 1'b1; burst_len = 8'd1; step = 4'd2; dir = 1'b0;
    tick();
    start = 1'b0;
    chk("t5_restart", outs(), exp_outs(1, 1, 0, 0, 8'h00));
    tick(); chk("t5_restart_done", outs(), exp_outs(0, 1, 1, 0, 8'h02));
    tick();

`ifdef ADDR_SEQ_ABORT_EN
    // Test 6: abort on the third beat of eight.
    load = 1'b1; load_value = 8'h20;
    start = 1'b1; burst_len = 8'd8; step = 4'd1; dir = 1'b0; addr_ready = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    chk("t6_b0", outs(), exp_outs(1, 1, 0, 0, 8'h20));
    tick(); chk("t6_b1", outs(), exp_outs(1, 1, 0, 0, 8'h21));
    tick(); chk("t6_b2", outs(), exp_outs(1, 1, 0, 0, 8'h22));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_done", outs(), exp_outs(0, 1, 1, 0, 8'h23));
    chk("t6_aborted", {31'd0, aborted}, 32'd1);
    tick();
    chk("t6_idle", outs(), exp_outs(0, 0, 0, 0, 8'h23));
    chk("t6_aborted_clear", {31'd0, aborted}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
